// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator for a word-wide
// data memory. Sub-word stores are done as read-modify-write.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word
// accesses are rejected with resp_err_o instead of being truncated.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | ready for a request; captures request fields on accept
// READ     | memory read strobe; memdata_i captured into rd_q
// WRITE    | memory write strobe; full or merged word on writedata_o
// RESP     | one-cycle completion pulse with load data or error
module load_store_unit #(
   parameter int MEM_WORDS = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o,
   output logic        memread_o,
   output logic        memwrite_o,
   output logic [31:0] memaddr_o,
   output logic [31:0] writedata_o,
   input  logic [31:0] memdata_i
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   generate
      if (MEM_WORDS < 1) begin : g_param_check
         $error("MEM_WORDS must be at least 1");
      end
   endgenerate

   logic [1:0]  state;
   logic        we_q;
   logic        uns_q;
   logic        err_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rd_q;
   logic        accept;
   logic        req_err;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] load_data;
   logic [31:0] merge_data;

   assign accept = (state == ST_IDLE) && req_valid_i;

   // Classify the incoming request as rejected before it is accepted.
   always_comb begin
      req_err = (req_size_i == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
      if ((req_size_i == 2'b01) && req_addr_i[0])
         req_err = 1'b1;
      if ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00))
         req_err = 1'b1;
`endif
   end

   // Sequencer and registered request fields.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state   <= ST_IDLE;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  we_q    <= req_we_i;
                  uns_q   <= req_unsigned_i;
                  err_q   <= req_err;
                  size_q  <= req_size_i;
                  addr_q  <= req_addr_i;
                  wdata_q <= req_wdata_i;
                  if (req_err)
                     state <= ST_RESP;
                  else if (req_we_i && (req_size_i == 2'b10))
                     state <= ST_WRITE;
                  else
                     state <= ST_READ;
               end
            end
            ST_READ: begin
               rd_q  <= memdata_i;
               state <= we_q ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: state <= ST_RESP;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   // Select the addressed lane of the read word and extend it.
   always_comb begin
      case (addr_q[1:0])
         2'd0:    lane_b = rd_q[7:0];
         2'd1:    lane_b = rd_q[15:8];
         2'd2:    lane_b = rd_q[23:16];
         default: lane_b = rd_q[31:24];
      endcase
      lane_h = addr_q[1] ? rd_q[31:16] : rd_q[15:0];
      case (size_q)
         2'b00:   load_data = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
         2'b01:   load_data = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
         default: load_data = rd_q;
      endcase
   end

   // Build the word to write: store data itself, or rd_q with one lane replaced.
   always_comb begin
      merge_data = rd_q;
      case (size_q)
         2'b00: begin
            case (addr_q[1:0])
               2'd0:    merge_data[7:0]   = wdata_q[7:0];
               2'd1:    merge_data[15:8]  = wdata_q[7:0];
               2'd2:    merge_data[23:16] = wdata_q[7:0];
               default: merge_data[31:24] = wdata_q[7:0];
            endcase
         end
         2'b01: begin
            if (addr_q[1])
               merge_data[31:16] = wdata_q[15:0];
            else
               merge_data[15:0]  = wdata_q[15:0];
         end
         default: merge_data = wdata_q;
      endcase
   end

   assign req_ready_o  = (state == ST_IDLE);
   assign memread_o    = (state == ST_READ);
   assign memwrite_o   = (state == ST_WRITE);
   assign memaddr_o    = (memread_o || memwrite_o) ? {2'b00, addr_q[31:2]} : 32'h0;
   assign writedata_o  = memwrite_o ? merge_data : 32'h0;
   assign resp_valid_o = (state == ST_RESP);
   assign resp_err_o   = resp_valid_o && err_q;
   assign resp_rdata_o = (resp_valid_o && !we_q && !err_q) ? load_data : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: behavioural word memory, response
// scoreboard and per-scenario tasks.
module tb_load_store_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_uns;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        memread;
   logic        memwrite;
   logic [31:0] memaddr;
   logic [31:0] writedata;
   logic [31:0] memdata;

   logic [31:0] mem [32];
   logic        pre_en;
   logic [4:0]  pre_idx;
   logic [31:0] pre_val;
   int          wr_count;

   int total;
   int bad;
   int resp_count;
   bit prev_rv;
   logic [32:0] exp_q[$];

   load_store_unit #(.MEM_WORDS(32)) dut (
      .clk_i(clk), .rst_i(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_uns),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
      .memread_o(memread), .memwrite_o(memwrite), .memaddr_o(memaddr),
      .writedata_o(writedata), .memdata_i(memdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign memdata = mem[memaddr[4:0]];

   always @(posedge clk) begin
      if (memwrite) begin
         mem[memaddr[4:0]] <= writedata;
         wr_count <= wr_count + 1;
      end else if (pre_en) begin
         mem[pre_idx] <= pre_val;
      end
   end

   // Scoreboard and protocol monitor.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_rv = 1'b0;
      end else begin
         total++;
         if (memread && memwrite) begin
            bad++;
            $display("FAIL strobe_excl rd=%b wr=%b required not both", memread, memwrite);
         end
         if (!memread && !memwrite) begin
            total++;
            if ({memaddr, writedata} !== 64'h0) begin
               bad++;
               $display("FAIL idle_bus addr=%h wdata=%h required 0", memaddr, writedata);
            end
         end
         if (resp_valid) begin
            resp_count++;
            total++;
            if (prev_rv) begin
               bad++;
               $display("FAIL resp_pulse got two consecutive cycles required one");
            end
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL resp_unexpected got err=%b rdata=%h required none", resp_err, resp_rdata);
            end else begin
               logic [32:0] e;
               e = exp_q.pop_front();
               if ({resp_err, resp_rdata} !== e) begin
                  bad++;
                  $display("FAIL resp_data got err=%b rdata=%h required err=%b rdata=%h",
                           resp_err, resp_rdata, e[32], e[31:0]);
               end
            end
         end
         prev_rv = resp_valid;
      end
   end

   task automatic set_word(input logic [4:0] idx, input logic [31:0] val);
      pre_idx = idx;
      pre_val = val;
      pre_en  = 1'b1;
      @(posedge clk);
      #1 pre_en = 1'b0;
   endtask

   task automatic check_word(input string name, input logic [4:0] idx, input logic [31:0] val);
      total++;
      if (mem[idx] !== val) begin
         bad++;
         $display("FAIL %s mem[%0d]=%h required %h", name, idx, mem[idx], val);
      end
   endtask

   // One request; caller is just after a rising edge with the unit idle.
   task automatic do_req(input string name, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                         input logic [31:0] exp_wdata);
      int n, nrd, nwr, exp_rd, exp_wr;
      logic [31:0] la, lw;
      bit seen;
      exp_rd = (!exp_err && (!we || size != 2'b10)) ? 1 : 0;
      exp_wr = (!exp_err && we) ? 1 : 0;
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s_ready got %b required 1", name, req_ready);
      end
      req_valid = 1'b1; req_we = we; req_size = size; req_uns = uns;
      req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      exp_q.push_back({exp_err, exp_rdata});
      #1;
      req_valid = 1'b0; req_we = ~we; req_size = ~size; req_uns = ~uns;
      req_addr = ~addr; req_wdata = ~wdata;
      n = 0; nrd = 0; nwr = 0; seen = 0; la = 32'h0; lw = 32'h0;
      while (!seen && n < 10) begin
         @(negedge clk);
         n++;
         if (memread)  nrd++;
         if (memwrite) begin nwr++; lw = writedata; end
         if (memread || memwrite) la = memaddr;
         if (resp_valid) seen = 1;
      end
      total++;
      if (!seen || n != exp_lat) begin
         bad++;
         $display("FAIL %s_latency got %0d (seen=%0d) required %0d", name, n, seen, exp_lat);
      end
      total++;
      if (nrd != exp_rd || nwr != exp_wr) begin
         bad++;
         $display("FAIL %s_strobes got rd=%0d wr=%0d required rd=%0d wr=%0d",
                  name, nrd, nwr, exp_rd, exp_wr);
      end
      if (exp_rd + exp_wr > 0) begin
         total++;
         if (la !== {2'b00, addr[31:2]}) begin
            bad++;
            $display("FAIL %s_memaddr got %h required %h", name, la, {2'b00, addr[31:2]});
         end
      end
      if (exp_wr > 0) begin
         total++;
         if (lw !== exp_wdata) begin
            bad++;
            $display("FAIL %s_writedata got %h required %h", name, lw, exp_wdata);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string name);
      total++;
      if ({req_ready, resp_valid, resp_err, memread, memwrite} !== 5'b10000 ||
          {resp_rdata, memaddr, writedata} !== 96'h0) begin
         bad++;
         $display("FAIL %s got rdy=%b rv=%b err=%b rd=%b wr=%b rdata=%h addr=%h wd=%h required rdy=1 rest 0",
                  name, req_ready, resp_valid, resp_err, memread, memwrite, resp_rdata, memaddr, writedata);
      end
   endtask

   task automatic test_reset();
      #2 check_reset_outputs("reset_state");
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_load();
      do_req("lb_u_0e", 1'b0, 2'b00, 1'b1, 32'h0E, 32'h0, 2, 32'h0000_0070, 1'b0, 32'h0);
      do_req("lb_s_0e", 1'b0, 2'b00, 1'b0, 32'h0E, 32'h0, 2, 32'h0000_0070, 1'b0, 32'h0);
      do_req("lb_s_0f", 1'b0, 2'b00, 1'b0, 32'h0F, 32'h0, 2, 32'hFFFF_FF80, 1'b0, 32'h0);
      do_req("lb_s_0d", 1'b0, 2'b00, 1'b0, 32'h0D, 32'h0, 2, 32'hFFFF_FFF0, 1'b0, 32'h0);
      do_req("lh_s_0e", 1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, 2, 32'hFFFF_8070, 1'b0, 32'h0);
      do_req("lh_u_0c", 1'b0, 2'b01, 1'b1, 32'h0C, 32'h0, 2, 32'h0000_F0A5, 1'b0, 32'h0);
      do_req("lh_s_0c", 1'b0, 2'b01, 1'b0, 32'h0C, 32'h0, 2, 32'hFFFF_F0A5, 1'b0, 32'h0);
      do_req("lw_0c",   1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 2, 32'h8070_F0A5, 1'b0, 32'h0);
   endtask

   task automatic test_store();
      do_req("sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, 32'hDEAD_BEEF);
      check_word("sw_10_mem", 5'd4, 32'hDEAD_BEEF);
      do_req("sb_0d", 1'b1, 2'b00, 1'b0, 32'h0D, 32'h1122_333C, 3, 32'h0, 1'b0, 32'h8070_3CA5);
      check_word("sb_0d_mem", 5'd3, 32'h8070_3CA5);
      do_req("sh_0e", 1'b1, 2'b01, 1'b0, 32'h0E, 32'h1234_BEEF, 3, 32'h0, 1'b0, 32'hBEEF_3CA5);
      check_word("sh_0e_mem", 5'd3, 32'hBEEF_3CA5);
      set_word(5'd3, 32'h8070_F0A5);
   endtask

   task automatic test_error();
      int w0;
      w0 = wr_count;
      do_req("ld_sz3", 1'b0, 2'b11, 1'b0, 32'h0C, 32'h0, 1, 32'h0, 1'b1, 32'h0);
      do_req("st_sz3", 1'b1, 2'b11, 1'b0, 32'h0C, 32'h5555_5555, 1, 32'h0, 1'b1, 32'h0);
      total++;
      if (wr_count != w0) begin
         bad++;
         $display("FAIL err_no_write got %0d writes required 0", wr_count - w0);
      end
      check_word("st_sz3_mem", 5'd3, 32'h8070_F0A5);
   endtask

   task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
      do_req("lh_0f", 1'b0, 2'b01, 1'b0, 32'h0F, 32'h0, 1, 32'h0, 1'b1, 32'h0);
      do_req("lw_0e", 1'b0, 2'b10, 1'b0, 32'h0E, 32'h0, 1, 32'h0, 1'b1, 32'h0);
      do_req("sw_0d", 1'b1, 2'b10, 1'b0, 32'h0D, 32'h0, 1, 32'h0, 1'b1, 32'h0);
      check_word("sw_0d_mem", 5'd3, 32'h8070_F0A5);
`else
      do_req("lh_0f", 1'b0, 2'b01, 1'b0, 32'h0F, 32'h0, 2, 32'hFFFF_8070, 1'b0, 32'h0);
      do_req("lw_0e", 1'b0, 2'b10, 1'b0, 32'h0E, 32'h0, 2, 32'h8070_F0A5, 1'b0, 32'h0);
`endif
   endtask

   task automatic test_back_to_back();
      logic [31:0] la [4];
      logic [1:0]  ls [4];
      logic        lu [4];
      logic [31:0] le [4];
      int acc [4];
      int k, cyc, r0, waited;
      bit rdy;
      la = '{32'h0E, 32'h0E, 32'h14, 32'h0F};
      ls = '{2'b00, 2'b01, 2'b10, 2'b00};
      lu = '{1'b1, 1'b0, 1'b0, 1'b0};
      le = '{32'h0000_0070, 32'hFFFF_8070, 32'h1234_5678, 32'hFFFF_FF80};
      r0 = resp_count;
      k = 0; cyc = 0;
      req_valid = 1'b1;
      while (k < 4 && cyc < 40) begin
         @(negedge clk);
         rdy = req_ready;
         if (rdy) begin
            req_we = 1'b0; req_size = ls[k]; req_uns = lu[k];
            req_addr = la[k]; req_wdata = 32'h0;
         end else begin
            req_we = 1'b1; req_size = 2'b10; req_uns = 1'b1;
            req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;
         end
         @(posedge clk);
         cyc++;
         if (rdy) begin
            exp_q.push_back({1'b0, le[k]});
            acc[k] = cyc;
            k++;
         end
      end
      #1 req_valid = 1'b0;
      total++;
      if (k != 4) begin
         bad++;
         $display("FAIL b2b_accepts got %0d required 4", k);
      end
      for (int i = 1; i < 4; i++) begin
         total++;
         if (i < k && acc[i] - acc[i-1] != 3) begin
            bad++;
            $display("FAIL b2b_spacing_%0d got %0d required 3", i, acc[i] - acc[i-1]);
         end
      end
      waited = 0;
      while (resp_count - r0 < 4 && waited < 10) begin
         @(posedge clk);
         waited++;
      end
      #1;
      total++;
      if (resp_count - r0 != 4) begin
         bad++;
         $display("FAIL b2b_resps got %0d required 4", resp_count - r0);
      end
      check_word("b2b_mem0", 5'd0, 32'h0);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_midop();
      int w0;
      w0 = wr_count;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_uns = 1'b0;
      req_addr = 32'h0D; req_wdata = 32'h0000_003C;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      total++;
      if (memread !== 1'b1) begin
         bad++;
         $display("FAIL rst_read_setup memread=%b required 1", memread);
      end
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("rst_mid_read");
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (wr_count != w0) begin
         bad++;
         $display("FAIL rst_read_nowrite got %0d writes required 0", wr_count - w0);
      end
      check_word("rst_read_mem", 5'd3, 32'h8070_F0A5);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
      req_addr = 32'h18; req_wdata = 32'hA5A5_5A5A;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      total++;
      if (memwrite !== 1'b1) begin
         bad++;
         $display("FAIL rst_write_setup memwrite=%b required 1", memwrite);
      end
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("rst_mid_write");
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_word("rst_write_mem", 5'd6, 32'h0);
   endtask

   initial begin
      total = 0; bad = 0; resp_count = 0; wr_count = 0; prev_rv = 1'b0;
      pre_en = 1'b0; pre_idx = '0; pre_val = '0;
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_uns = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      test_reset();
      set_word(5'd3, 32'h8070_F0A5);
      set_word(5'd5, 32'h1234_5678);
      test_load();
      test_store();
      test_error();
      test_misalign();
      test_back_to_back();
      exp_q.delete();
      test_reset_midop();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL sb_drain got %0d pending required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
